// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: NS main road, EW side road and a pedestrian walk phase.
// One-second prescaler, per-state countdown, request latching and emergency override.
module traffic_intersection_ctrl #(
    parameter int unsigned CLK_DIV  = 50000000,
    parameter int unsigned T_GREEN  = 9,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [3:0] second,
    output logic       tick
);

    localparam int unsigned    CntW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
    localparam logic [3:0]     SecGreen = 4'(T_GREEN);
    localparam logic [3:0]     SecYel   = 4'(T_YELLOW);
    localparam logic [3:0]     SecAr    = 4'(T_ALLRED);
    localparam logic [3:0]     SecWalk  = 4'(T_WALK);
    localparam logic [2:0]     LampR    = 3'b100;
    localparam logic [2:0]     LampY    = 3'b010;
    localparam logic [2:0]     LampG    = 3'b001;

    typedef enum logic [2:0] {
        StNsG, StNsY, StAr1, StEwG, StEwY, StAr2, StWalk, StEmerg
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      sec_q, sec_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            side_pend_q, side_pend_d;
    logic            ped_pend_q, ped_pend_d;
    logic            emerg_lat_q, emerg_lat_d;
    logic            expire;

    function automatic logic [3:0] duration(input state_e s);
        case (s)
            StNsG, StEwG: return SecGreen;
            StNsY, StEwY: return SecYel;
            StAr1, StAr2: return SecAr;
            StWalk:       return SecWalk;
            default:      return 4'd0;
        endcase
    endfunction

    assign tick   = (cnt_q == CntMax);
    assign expire = tick && (sec_q == 4'd1);
    assign second = sec_q;

    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        cnt_d       = tick ? '0 : cnt_q + CntW'(1);
        emerg_lat_d = emerg_lat_q;
        if (tick && (sec_q > 4'd1)) begin
            sec_d = sec_q - 4'd1;
        end

        // Emergency seen during green or yellow is remembered so the yellow still ends in EMERG.
        unique case (state_q)
            StNsG: begin
                if (emerg) begin
                    state_d     = StNsY;
                    emerg_lat_d = 1'b1;
                end else if (expire) begin
                    if (side_pend_q || ped_pend_q) state_d = StNsY;
                    else                           sec_d   = SecGreen;
                end
            end
            StNsY: begin
                if (emerg) emerg_lat_d = 1'b1;
                if (expire) begin
                    state_d     = (emerg || emerg_lat_q) ? StEmerg : StAr1;
                    emerg_lat_d = 1'b0;
                end
            end
            StAr1: begin
                if (emerg)       state_d = StEmerg;
                else if (expire) state_d = ped_pend_q ? StWalk : StEwG;
            end
            StWalk: begin
                if (emerg)       state_d = StEmerg;
                else if (expire) state_d = side_pend_q ? StEwG : StNsG;
            end
            StEwG: begin
                if (emerg) begin
                    state_d     = StEwY;
                    emerg_lat_d = 1'b1;
                end else if (expire) begin
                    state_d = StEwY;
                end
            end
            StEwY: begin
                if (emerg) emerg_lat_d = 1'b1;
                if (expire) begin
                    state_d     = (emerg || emerg_lat_q) ? StEmerg : StAr2;
                    emerg_lat_d = 1'b0;
                end
            end
            StAr2: begin
                if (emerg)       state_d = StEmerg;
                else if (expire) state_d = StNsG;
            end
            StEmerg: begin
                if (!emerg) state_d = StAr2;
            end
            default: state_d = StNsG;
        endcase

        // Any state change restarts the second so the new state gets whole seconds.
        if (state_d != state_q) begin
            cnt_d = '0;
            sec_d = duration(state_d);
        end

        side_pend_d = side_req || (side_pend_q && !((state_d == StEwG) && (state_q != StEwG)));
        ped_pend_d  = ped_req  || (ped_pend_q  && !((state_d == StWalk) && (state_q != StWalk)));
    end

    always_comb begin
        ns_light = LampR;
        ew_light = LampR;
        walk     = 1'b0;
        unique case (state_q)
            StNsG:   ns_light = LampG;
            StNsY:   ns_light = LampY;
            StEwG:   ew_light = LampG;
            StEwY:   ew_light = LampY;
            StWalk:  walk     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StNsG;
            sec_q       <= SecGreen;
            cnt_q       <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            emerg_lat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            cnt_q       <= cnt_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            emerg_lat_q <= emerg_lat_d;
        end
    end

endmodule
